// File: rtl/car_alarm_chime_controller.sv
// car_alarm_chime_controller: qualifies CarAlarmSignal and drives timed buzzer beeps with ack and beep limit.
// Defining CHIME_CONTINUOUS_EN removes the MAX_BEEPS limit so chiming runs until ack or deassert.
module car_alarm_chime_controller #(
  parameter int QUAL_CYCLES = 4,
  parameter int ON_CYCLES   = 3,
  parameter int OFF_CYCLES  = 2,
  parameter int MAX_BEEPS   = 5
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       CarAlarmSignal,
  input  logic       AckButton,
  output logic       ChimeOut,
  output logic       AlarmActive,
  output logic [7:0] BeepCount
);
  typedef enum logic [2:0] {IDLE, QUALIFY, BEEP_ON, BEEP_OFF, HOLD} state_t;
  localparam logic [15:0] QUAL_LAST = 16'(QUAL_CYCLES - 1);
  localparam logic [15:0] ON_LOAD   = 16'(ON_CYCLES - 1);
  localparam logic [15:0] OFF_LOAD  = 16'(OFF_CYCLES - 1);
  localparam logic [7:0]  MAX_B     = 8'(MAX_BEEPS);
`ifdef CHIME_CONTINUOUS_EN
  localparam logic LIMIT_EN = 1'b0;
`else
  localparam logic LIMIT_EN = 1'b1;
`endif
  state_t state_q, state_d;
  logic [15:0] qual_q, qual_d, timer_q, timer_d;
  logic [7:0] count_q, count_d;
  logic chime_q, chime_d, active_q, active_d, enter_on;
  always_comb begin
    state_d  = state_q;
    qual_d   = qual_q;
    timer_d  = timer_q;
    count_d  = count_q;
    enter_on = 1'b0;
    case (state_q)
      IDLE: if (CarAlarmSignal) begin
        if (QUAL_CYCLES == 1) enter_on = 1'b1;
        else begin
          state_d = QUALIFY;
          qual_d  = 16'd1;
        end
      end
      QUALIFY: if (qual_q == QUAL_LAST) enter_on = 1'b1; else qual_d = qual_q + 16'd1;
      BEEP_ON: begin
        if (AckButton) state_d = HOLD;
        else if (timer_q == 16'd0) begin
          state_d = (LIMIT_EN && count_q == MAX_B) ? HOLD : BEEP_OFF;
          timer_d = OFF_LOAD;
        end else timer_d = timer_q - 16'd1;
      end
      BEEP_OFF: begin
        if (AckButton) state_d = HOLD;
        else if (timer_q == 16'd0) enter_on = 1'b1;
        else timer_d = timer_q - 16'd1;
      end
      HOLD: state_d = HOLD;
      default: state_d = IDLE;
    endcase
    if (enter_on) begin
      state_d = BEEP_ON;
      qual_d  = 16'd0;
      timer_d = ON_LOAD;
      count_d = (count_q == 8'hff) ? count_q : count_q + 8'd1;
    end
    // deassert outranks ack and timer expiry in every qualified or qualifying state
    if (state_q != IDLE && !CarAlarmSignal) begin
      state_d = IDLE;
      qual_d  = 16'd0;
      timer_d = 16'd0;
      count_d = 8'd0;
    end
    chime_d  = state_d == BEEP_ON;
    active_d = state_d inside {BEEP_ON, BEEP_OFF, HOLD};
  end
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      qual_q   <= 16'd0;
      timer_q  <= 16'd0;
      count_q  <= 8'd0;
      chime_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      qual_q   <= qual_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      chime_q  <= chime_d;
      active_q <= active_d;
    end
  end
  assign ChimeOut    = chime_q;
  assign AlarmActive = active_q;
  assign BeepCount   = count_q;
endmodule

// File: tb/tb_car_alarm_chime_controller.sv
// tb_car_alarm_chime_controller: directed vectors feed a scoreboard queue checked by a negedge monitor.
module tb_car_alarm_chime_controller;
  logic clk = 1'b0, reset_L = 1'b0, alarm = 1'b0, ack = 1'b0;
  logic chime, active;
  logic [7:0] count;
  typedef struct {
    string      name;
    logic       c;
    logic       a;
    logic [7:0] n;
  } exp_t;
  exp_t q[$];
  string phase = "init";
  int checks = 0, failures = 0;
  bit done = 1'b0;

  car_alarm_chime_controller dut (
    .clk(clk), .reset_L(reset_L), .CarAlarmSignal(alarm), .AckButton(ack),
    .ChimeOut(chime), .AlarmActive(active), .BeepCount(count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({chime, active, count} !== {e.c, e.a, e.n}) begin
        failures++;
        $display("FAIL %s: chime/active/count got %b/%b/%0d want %b/%b/%0d",
                 e.name, chime, active, count, e.c, e.a, e.n);
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic k,
                      input logic c, input logic a, input logic [7:0] n);
    reset_L = r;
    alarm   = s;
    ack     = k;
    @(posedge clk);
    q.push_back('{name: phase, c: c, a: a, n: n});
    @(negedge clk);
  endtask

  task automatic quiet(input int cyc, input logic s);
    repeat (cyc) step(1'b1, s, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic beep(input logic [7:0] n, input logic gap);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, n);
    if (gap) repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, n);
  endtask

  initial begin
    #1000000;
    if (!done) begin
      failures++;
      $display("FAIL timeout: stimulus did not complete in phase %s", phase);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    phase = "reset";
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    checks++;
    if ({chime, active, count} !== 10'b0) begin
      failures++;
      $display("FAIL reset_state: chime/active/count got %b/%b/%0d want 0/0/0",
               chime, active, count);
    end
    phase = "qualify_after_reset";
    quiet(3, 1'b1);
`ifdef CHIME_CONTINUOUS_EN
    phase = "continuous";
    for (int b = 1; b <= 300; b++) beep((b > 255) ? 8'd255 : 8'(b), 1'b1);
`else
    phase = "full_pattern";
    for (int b = 1; b <= 5; b++) beep(8'(b), b < 5);
    phase = "hold_after_limit";
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5);
`endif
    phase = "deassert";
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    phase = "glitch";
    quiet(3, 1'b1);
    quiet(3, 1'b0);
    phase = "ack";
    quiet(3, 1'b1);
    beep(8'd1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
    phase = "ack_release";
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    phase = "ack_and_deassert";
    quiet(3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    phase = "reraise_ack_ignored";
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1);
    phase = "ack_in_beep";
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    phase = "reset_mid_beep";
    quiet(3, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
